// File: rtl/hps_reset_req_sequencer.sv
// Turns level reset requests (cold/warm/debug) into one-at-a-time active-low HPS
// reset-request pulses, waits for the HPS reset handshake and enforces an idle gap.
module hps_reset_req_sequencer #(
    parameter int COLD_PULSE  = 6,
    parameter int WARM_PULSE  = 2,
    parameter int DEBUG_PULSE = 32,
    parameter int CNT_WIDTH   = 20,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int HOLDOFF     = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req_in,
    input  logic       hps_fpga_reset,
    output logic       cold_req_n,
    output logic       warm_req_n,
    output logic       debug_req_n,
    output logic       busy,
    output logic       ack_timeout,
    output logic [1:0] last_req
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_WAIT_ACK,
        ST_WAIT_REL,
        ST_HOLDOFF
    } state_t;

    localparam logic [1:0] T_NONE  = 2'd0;
    localparam logic [1:0] T_COLD  = 2'd1;
    localparam logic [1:0] T_WARM  = 2'd2;
    localparam logic [1:0] T_DEBUG = 2'd3;

    localparam logic [CNT_WIDTH-1:0] C_COLD  = CNT_WIDTH'(COLD_PULSE);
    localparam logic [CNT_WIDTH-1:0] C_WARM  = CNT_WIDTH'(WARM_PULSE);
    localparam logic [CNT_WIDTH-1:0] C_DEBUG = CNT_WIDTH'(DEBUG_PULSE);
    localparam logic [CNT_WIDTH-1:0] C_ACK   = CNT_WIDTH'(ACK_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] C_HOLD  = CNT_WIDTH'(HOLDOFF);
    localparam logic [CNT_WIDTH-1:0] C_ONE   = CNT_WIDTH'(1);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [2:0]           pending, pending_nxt, pend_merge;
    logic [2:0]           req_q, req_edge;
    logic [2:0]           req_n_q, req_n_nxt;
    logic                 busy_nxt;
    logic                 ack_timeout_nxt;
    logic [1:0]           last_req_nxt;
    logic [1:0]           sel;

    // Fixed priority: cold > warm > debug
    function automatic logic [1:0] pick_type(input logic [2:0] p);
        if (p[0])      return T_COLD;
        else if (p[1]) return T_WARM;
        else if (p[2]) return T_DEBUG;
        else           return T_NONE;
    endfunction

    function automatic logic [2:0] type_mask(input logic [1:0] t);
        case (t)
            T_COLD:  return 3'b001;
            T_WARM:  return 3'b010;
            T_DEBUG: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] pulse_len(input logic [1:0] t);
        case (t)
            T_COLD:  return C_COLD;
            T_WARM:  return C_WARM;
            T_DEBUG: return C_DEBUG;
            default: return C_ONE;
        endcase
    endfunction

    always_comb begin
        req_edge        = req_in & ~req_q;
        pend_merge      = pending | req_edge;
        sel             = pick_type(pend_merge);
        state_nxt       = state;
        cnt_nxt         = cnt;
        pending_nxt     = pend_merge;
        req_n_nxt       = 3'b111;
        ack_timeout_nxt = ack_timeout;
        last_req_nxt    = last_req;

        case (state)
            ST_IDLE: begin
                if (pend_merge != 3'b000) begin
                    last_req_nxt = sel;
                    pending_nxt  = pend_merge & ~type_mask(sel);
                    cnt_nxt      = pulse_len(sel);
                    req_n_nxt    = ~type_mask(sel);
                    state_nxt    = ST_PULSE;
                end
            end
            ST_PULSE: begin
                // Outputs are registered, so the last low cycle is the one where cnt==1
                if (cnt == C_ONE) begin
                    if (last_req == T_DEBUG) begin
                        state_nxt = ST_HOLDOFF;
                        cnt_nxt   = C_HOLD;
                    end else begin
                        state_nxt = ST_WAIT_ACK;
                        cnt_nxt   = C_ACK;
                    end
                end else begin
                    cnt_nxt   = cnt - C_ONE;
                    req_n_nxt = ~type_mask(last_req);
                end
            end
            ST_WAIT_ACK: begin
                if (hps_fpga_reset) begin
                    state_nxt = ST_WAIT_REL;
                    cnt_nxt   = C_ACK;
                end else if (cnt == C_ONE) begin
                    ack_timeout_nxt = 1'b1;
                    state_nxt       = ST_HOLDOFF;
                    cnt_nxt         = C_HOLD;
                end else begin
                    cnt_nxt = cnt - C_ONE;
                end
            end
            ST_WAIT_REL: begin
                if (!hps_fpga_reset) begin
                    state_nxt = ST_HOLDOFF;
                    cnt_nxt   = C_HOLD;
                end else if (cnt == C_ONE) begin
                    ack_timeout_nxt = 1'b1;
                    state_nxt       = ST_HOLDOFF;
                    cnt_nxt         = C_HOLD;
                end else begin
                    cnt_nxt = cnt - C_ONE;
                end
            end
            ST_HOLDOFF: begin
                if (cnt == C_ONE) begin
                    state_nxt = ST_IDLE;
                    // A finished cold reset makes any queued warm/debug request moot
                    if (last_req == T_COLD) pending_nxt = 3'b000;
                end else begin
                    cnt_nxt = cnt - C_ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pending     <= 3'b000;
            req_q       <= 3'b000;
            req_n_q     <= 3'b111;
            busy        <= 1'b0;
            ack_timeout <= 1'b0;
            last_req    <= T_NONE;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            pending     <= pending_nxt;
            req_q       <= req_in;
            req_n_q     <= req_n_nxt;
            busy        <= busy_nxt;
            ack_timeout <= ack_timeout_nxt;
            last_req    <= last_req_nxt;
        end
    end

    assign cold_req_n  = req_n_q[0];
    assign warm_req_n  = req_n_q[1];
    assign debug_req_n = req_n_q[2];

endmodule

// File: tb/tb_hps_reset_req_sequencer.sv
// Directed bench for hps_reset_req_sequencer; the acknowledge timeout is shortened
// so the timeout path fits in a short run.
module tb_hps_reset_req_sequencer;

    localparam int T_ACK = 300;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] req_in;
    logic       hps_fpga_reset;
    logic       cold_req_n, warm_req_n, debug_req_n;
    logic       busy, ack_timeout;
    logic [1:0] last_req;

    int n_tests = 0;
    int n_fail  = 0;

    hps_reset_req_sequencer #(
        .COLD_PULSE (6),
        .WARM_PULSE (2),
        .DEBUG_PULSE(32),
        .CNT_WIDTH  (20),
        .ACK_TIMEOUT(T_ACK),
        .HOLDOFF    (1000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_in        (req_in),
        .hps_fpga_reset(hps_fpga_reset),
        .cold_req_n    (cold_req_n),
        .warm_req_n    (warm_req_n),
        .debug_req_n   (debug_req_n),
        .busy          (busy),
        .ack_timeout   (ack_timeout),
        .last_req      (last_req)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Samples the three req_n lines on the next n falling edges
    task automatic capture(input int n, output logic [63:0] c, output logic [63:0] w,
                           output logic [63:0] d);
        c = '0; w = '0; d = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            c[i] = cold_req_n;
            w[i] = warm_req_n;
            d[i] = debug_req_n;
        end
    endtask

    task automatic count_busy(input int budget, output int cnt);
        bit done;
        done = 1'b0;
        cnt  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (busy) cnt++;
            else begin
                done = 1'b1;
                break;
            end
        end
        if (!done) cnt = -1;
    endtask

    task automatic ack_and_drain(input int hi_delay, input int lo_delay, output int cnt);
        step(hi_delay);
        hps_fpga_reset = 1'b1;
        step(lo_delay);
        hps_fpga_reset = 1'b0;
        count_busy(3000, cnt);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        req_in = 3'b000;
        hps_fpga_reset = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
    endtask

    initial begin
        logic [63:0] c, w, d;
        int bc, dc, cl, other;

        reset = 1'b1;
        req_in = 3'b000;
        hps_fpga_reset = 1'b0;
        step(3);
        check_val("rst_cold_n",  cold_req_n,  1'b1);
        check_val("rst_warm_n",  warm_req_n,  1'b1);
        check_val("rst_debug_n", debug_req_n, 1'b1);
        check_val("rst_busy",    busy,        1'b0);
        check_val("rst_ack_to",  ack_timeout, 1'b0);
        check_val("rst_last",    last_req,    2'd0);
        reset = 1'b0;
        step(2);

        // 1: single cold request, normal handshake
        check_val("t1_pre_cold", cold_req_n, 1'b1);
        req_in = 3'b001;
        capture(8, c, w, d);
        req_in = 3'b000;
        check_val("t1_cold_pat", c, 64'h00000000_000000C0);
        check_val("t1_wd_pat",   w & d, 64'h00000000_000000FF);
        check_val("t1_busy_mid", busy, 1'b1);
        ack_and_drain(2, 50, bc);
        check_val("t1_holdoff", bc, 1000);
        check_val("t1_last",    last_req, 2'd1);
        check_val("t1_ack_to",  ack_timeout, 1'b0);

        // 2: all three at once, cold wins and clears the rest
        step(5);
        req_in = 3'b111;
        capture(8, c, w, d);
        req_in = 3'b000;
        check_val("t2_cold_pat", c, 64'h00000000_000000C0);
        check_val("t2_warm_pat", w, 64'h00000000_000000FF);
        check_val("t2_dbg_pat",  d, 64'h00000000_000000FF);
        ack_and_drain(2, 50, bc);
        check_val("t2_holdoff", bc, 1000);
        capture(50, c, w, d);
        check_val("t2_no_more", c & w & d, 64'h0003FFFF_FFFFFFFF);
        check_val("t2_idle",    busy, 1'b0);
        check_val("t2_last",    last_req, 2'd1);

        // 3: warm, then debug arriving while waiting for the ack
        req_in = 3'b010;
        capture(4, c, w, d);
        check_val("t3_warm_pat", w, 64'h00000000_0000000C);
        check_val("t3_cold_pat", c & d, 64'h00000000_0000000F);
        req_in = 3'b100;
        step(1);
        req_in = 3'b000;
        check_val("t3_last_w", last_req, 2'd2);
        ack_and_drain(3, 20, bc);
        check_val("t3_holdoff_w", bc, 1000);
        bc = 0; dc = 0; other = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy) break;
            bc++;
            if (!debug_req_n) dc++;
            if (!cold_req_n || !warm_req_n) other++;
        end
        check_val("t3_dbg_low",  dc, 32);
        check_val("t3_dbg_busy", bc, 1032);
        check_val("t3_other",    other, 0);
        check_val("t3_ack_to",   ack_timeout, 1'b0);
        check_val("t3_last_d",   last_req, 2'd3);

        // 4: warm with no acknowledge -> timeout after exactly T_ACK cycles
        step(3);
        req_in = 3'b010;
        step(1);
        req_in = 3'b000;
        step(T_ACK + 1);
        check_val("t4_ack_to_early", ack_timeout, 1'b0);
        step(1);
        check_val("t4_ack_to_set", ack_timeout, 1'b1);
        check_val("t4_busy", busy, 1'b1);
        count_busy(3000, bc);
        check_val("t4_holdoff", bc, 999);
        step(5);
        check_val("t4_ack_sticky", ack_timeout, 1'b1);
        check_val("t4_last", last_req, 2'd2);

        // 5: cold held high for a long time -> one pulse only
        do_reset();
        check_val("t5_ack_cleared", ack_timeout, 1'b0);
        req_in = 3'b001;
        cl = 0; other = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!cold_req_n) cl++;
            if (!warm_req_n || !debug_req_n) other++;
            hps_fpga_reset = (i >= 10 && i < 60);
        end
        req_in = 3'b000;
        check_val("t5_cold_low", cl, 6);
        check_val("t5_other",    other, 0);
        check_val("t5_idle",     busy, 1'b0);
        check_val("t5_ack_to",   ack_timeout, 1'b0);

        // 6: reset in the middle of a debug pulse, with a warm request queued
        step(3);
        req_in = 3'b100;
        step(2);
        req_in = 3'b110;
        step(1);
        check_val("t6_dbg_active", debug_req_n, 1'b0);
        reset  = 1'b1;
        req_in = 3'b000;
        step(1);
        check_val("t6_dbg_rel", debug_req_n, 1'b1);
        check_val("t6_busy",    busy, 1'b0);
        check_val("t6_last",    last_req, 2'd0);
        reset = 1'b0;
        capture(10, c, w, d);
        check_val("t6_pend_clr", busy, 1'b0);
        check_val("t6_quiet", c & w & d, 64'h00000000_000003FF);
        req_in = 3'b010;
        capture(4, c, w, d);
        req_in = 3'b000;
        check_val("t6_warm_pat", w, 64'h00000000_0000000C);
        ack_and_drain(3, 20, bc);
        check_val("t6_holdoff", bc, 1000);
        check_val("t6_last_w",  last_req, 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
